// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by fetch, decode and execute.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        INST_R,
        INST_I,
        INST_S,
        INST_B,
        INST_U,
        INST_J
    } inst_type_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the memory response path and decode.
// Head entry is read straight from storage; flush empties it in one cycle.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests
// and buffers in-order responses for decode; redirects drop in-flight fetches.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [XLEN-1:0]       out_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENTRY_W = INST_WIDTH + XLEN;
    localparam logic [31:0] MAX_OUT_U = MAX_OUTSTANDING;
    localparam logic [31:0] DEPTH_U   = FIFO_DEPTH;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    resp_pc;
    logic [XLEN-1:0]    target;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   outstanding_next;
    logic [OUT_W-1:0]   drop_cnt;
    logic               fetch_en;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [31:0]        live_entries;
    logic               req_fire;
    logic               resp_drop;
    logic               push;
    logic               pop;

    assign target = align_word(redirect_pc);

    // Entries that will eventually occupy the FIFO: live in-flight plus buffered.
    assign live_entries = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);

    assign imem_req_valid = fetch_en && (32'(outstanding) < MAX_OUT_U)
                          && (live_entries < DEPTH_U) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign push      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop       = out_ready && !fifo_empty && !redirect_valid;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire)
            outstanding_next = outstanding_next + OUT_W'(1);
        if (imem_resp_valid && (outstanding != '0))
            outstanding_next = outstanding_next - OUT_W'(1);
    end

    // fetch_en holds off requests until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
                if (push)      resp_pc  <= resp_pc + PC_STEP;
                if (resp_drop) drop_cnt <= drop_cnt - OUT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_resp_data, resp_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_inst  = fifo_empty ? '0 : head[ENTRY_W-1:XLEN];
    assign out_pc    = fifo_empty ? '0 : head[XLEN-1:0];

    a_no_resp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding != '0));

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!fifo_full || pop));

endmodule
